// File: rtl/cla_pipe_arbiter_if.sv
// Request, datapath and response bundle for cla_pipe_arbiter.
// slave = arbiter view, master = requester/datapath view.
interface cla_pipe_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 64
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [W-1:0]      pipe_a;
    logic [W-1:0]      pipe_b;
    logic [W-1:0]      pipe_sum;
    logic              pipe_cout;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [NREQ*W-1:0] rsp_sum;
    logic [NREQ-1:0]   rsp_cout;
    logic              busy;

    modport slave (
        input  req_valid, req_a, req_b, pipe_sum, pipe_cout, rsp_ready,
        output req_ready, pipe_a, pipe_b, rsp_valid, rsp_sum, rsp_cout, busy
    );

    modport master (
        output req_valid, req_a, req_b, pipe_sum, pipe_cout, rsp_ready,
        input  req_ready, pipe_a, pipe_b, rsp_valid, rsp_sum, rsp_cout, busy
    );
endinterface

// File: rtl/cla_pipe_arbiter.sv
// Shares a free-running LAT-stage CLA adder among NREQ requesters; credits reserve FIFO space per op.
// Round-robin by default; define ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module cla_pipe_arbiter #(
    parameter int NREQ      = 4,
    parameter int W         = 64,
    parameter int LAT       = 7,
    parameter int RSP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    cla_pipe_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int AW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int PW = $clog2(RSP_DEPTH) + 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [LAT-1:0]  sr_vld;
    logic [IW-1:0]   sr_tag [LAT];
    logic [CW-1:0]   credit [NREQ];
    logic [PW-1:0]   wr_ptr [NREQ];
    logic [PW-1:0]   rd_ptr [NREQ];
    logic [W:0]      mem    [NREQ][RSP_DEPTH];
`ifndef ARB_FIXED_PRIO_EN
    logic [IW-1:0]   rr_ptr;
`endif

    logic [NREQ-1:0]   elig, gnt, pop, fifo_ne;
    logic              gnt_any;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     cand;
    logic              cap_vld;
    logic [IW-1:0]     cap_tag;
    logic [W-1:0]      pipe_a_w, pipe_b_w;
    logic [NREQ*W-1:0] rsp_sum_w;
    logic [NREQ-1:0]   rsp_cout_w;

    assign cap_vld = sr_vld[LAT-1];
    assign cap_tag = sr_tag[LAT-1];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i]    = bus.req_valid[i] && (credit[i] != '0);
            fifo_ne[i] = (wr_ptr[i] != rd_ptr[i]);
            pop[i]     = fifo_ne[i] && bus.rsp_ready[i];
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!rst) begin
            for (int off = 0; off < NREQ; off++) begin
`ifdef ARB_FIXED_PRIO_EN
                cand = IW'(off);
`else
                cand = IW'((int'(rr_ptr) + off) % NREQ);
`endif
                if (!gnt_any && elig[cand]) begin
                    gnt_any   = 1'b1;
                    gnt_idx   = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        pipe_a_w = '0;
        pipe_b_w = '0;
        if (gnt_any) begin
            pipe_a_w = bus.req_a[int'(gnt_idx)*W +: W];
            pipe_b_w = bus.req_b[int'(gnt_idx)*W +: W];
        end
    end

    // FIFO heads are read straight from storage: a push becomes visible one cycle later.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            rsp_sum_w[i*W +: W] = mem[i][AW'(int'(rd_ptr[i]) % RSP_DEPTH)][W-1:0];
            rsp_cout_w[i]       = mem[i][AW'(int'(rd_ptr[i]) % RSP_DEPTH)][W];
        end
    end

    assign bus.req_ready = gnt;
    assign bus.pipe_a    = pipe_a_w;
    assign bus.pipe_b    = pipe_b_w;
    assign bus.rsp_valid = fifo_ne;
    assign bus.rsp_sum   = rsp_sum_w;
    assign bus.rsp_cout  = rsp_cout_w;
    assign bus.busy      = (|sr_vld) | (|fifo_ne);

    always_ff @(posedge clk) begin
        sr_tag[0] <= gnt_idx;
        for (int k = 1; k < LAT; k++) sr_tag[k] <= sr_tag[k-1];
        if (rst) begin
            sr_vld <= '0;
            for (int i = 0; i < NREQ; i++) begin
                credit[i] <= CW'(RSP_DEPTH);
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
`ifndef ARB_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            sr_vld[0] <= gnt_any;
            for (int k = 1; k < LAT; k++) sr_vld[k] <= sr_vld[k-1];
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && !pop[i])
                    credit[i] <= credit[i] - 1'b1;
                else if (!gnt[i] && pop[i])
                    credit[i] <= credit[i] + 1'b1;
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (cap_vld && (cap_tag == IW'(i))) begin
                    mem[i][AW'(int'(wr_ptr[i]) % RSP_DEPTH)] <= {bus.pipe_cout, bus.pipe_sum};
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
            end
`ifndef ARB_FIXED_PRIO_EN
            if (gnt_any)
                rr_ptr <= (gnt_idx == IW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
`endif
        end
    end

    // Credits reserve the slot at issue time, so a returning sum always finds room.
    push_never_full: assert property (@(posedge clk) disable iff (rst)
        cap_vld |-> ((wr_ptr[cap_tag] - rd_ptr[cap_tag]) != PW'(RSP_DEPTH)));
endmodule
